// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction Fetch stage of the pipelined MIPS32 core. Owns the PC, selects the
// next PC (exception vector, branch/jump target, PC+4), runs the request/ready
// handshake with instruction memory and hands one instruction per delivery to
// the IF/ID register together with its PC, PC+4 and delay-slot status.
//
// Ports
//   clock            in   system clock, all state on rising edge
//   reset            in   synchronous, active-low reset
//   ID_Stall         in   IF/ID is holding, no delivery this cycle
//   ID_IsBranch      in   instruction in ID is a branch/jump
//   ID_PCSrc         in   branch/jump in ID is taken
//   ID_BranchTarget  in   taken target
//   EXC_Redirect     in   exception/ERET redirect (highest priority)
//   EXC_Vector       in   redirect address
//   InstMem_Read     out  fetch request
//   InstMem_Address  out  word address of the request
//   InstMem_Ready    in   response valid (may coincide with the request)
//   InstMem_In       in   instruction data, valid with InstMem_Ready
//   IF_Instruction   out  fetched instruction, 0 when IF_Stall=1
//   IF_PC            out  PC of IF_Instruction
//   IF_PCAdd4        out  IF_PC + 4 (wraps)
//   IF_IsBDS         out  IF_Instruction is a branch delay slot
//   IF_Stall         out  no valid instruction this cycle
// -----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ID_Stall,
    input  logic        ID_IsBranch,
    input  logic        ID_PCSrc,
    input  logic [31:0] ID_BranchTarget,
    input  logic        EXC_Redirect,
    input  logic [31:0] EXC_Vector,
    output logic        InstMem_Read,
    output logic [29:0] InstMem_Address,
    input  logic        InstMem_Ready,
    input  logic [31:0] InstMem_In,
    output logic [31:0] IF_Instruction,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_PCAdd4,
    output logic        IF_IsBDS,
    output logic        IF_Stall
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t      state_r, state_nx_s;
    logic [31:0] pc_r, pc_nx_s;
    logic [31:0] hold_r, hold_nx_s;
    logic [31:0] tgt_r, tgt_nx_s;
    logic [29:0] disc_addr_r, disc_addr_nx_s;
    logic        bds_pending_r, bds_pending_nx_s;
    logic        tgt_pending_r, tgt_pending_nx_s;

    logic        valid_s;
    logic        deliver_s;
    logic        bds_s;
    logic [31:0] pc_add4_s;
    logic [31:0] next_pc_s;

    // Delivery qualification, next-PC selection and IF/ID-facing outputs.
    always_comb begin
        valid_s   = 1'b0;
        pc_add4_s = pc_r + 32'd4;
        case (state_r)
            ST_FETCH:   valid_s = InstMem_Ready;
            ST_HOLD:    valid_s = 1'b1;
            ST_DISCARD: valid_s = 1'b0;
            default:    valid_s = 1'b0;
        endcase

        // A redirect cycle never delivers, whatever the memory does.
        deliver_s = reset & valid_s & ~ID_Stall & ~EXC_Redirect;
        bds_s     = reset & (ID_IsBranch | bds_pending_r);

        if (EXC_Redirect) begin
            next_pc_s = EXC_Vector;
        end else if (bds_s && ID_PCSrc && ID_IsBranch) begin
            next_pc_s = ID_BranchTarget;
        end else if (tgt_pending_r) begin
            next_pc_s = tgt_r;
        end else begin
            next_pc_s = pc_add4_s;
        end

        InstMem_Read    = reset & (state_r != ST_HOLD);
        // DISCARD keeps the abandoned request's address stable until Ready.
        InstMem_Address = (state_r == ST_DISCARD) ? disc_addr_r : pc_r[31:2];

        if (!deliver_s) begin
            IF_Instruction = 32'd0;
        end else if (state_r == ST_HOLD) begin
            IF_Instruction = hold_r;
        end else begin
            IF_Instruction = InstMem_In;
        end

        IF_Stall = ~deliver_s;
        IF_IsBDS = bds_s;
        if (reset) begin
            IF_PC     = pc_r;
            IF_PCAdd4 = pc_add4_s;
        end else begin
            IF_PC     = RESET_VECTOR;
            IF_PCAdd4 = RESET_VECTOR + 32'd4;
        end
    end

    // Next-state logic for the fetch FSM, PC and delay-slot bookkeeping.
    always_comb begin
        state_nx_s       = state_r;
        pc_nx_s          = pc_r;
        hold_nx_s        = hold_r;
        tgt_nx_s         = tgt_r;
        disc_addr_nx_s   = disc_addr_r;
        bds_pending_nx_s = bds_pending_r;
        tgt_pending_nx_s = tgt_pending_r;

        if (EXC_Redirect) begin
            pc_nx_s          = EXC_Vector;
            hold_nx_s        = 32'd0;
            bds_pending_nx_s = 1'b0;
            tgt_pending_nx_s = 1'b0;
            case (state_r)
                ST_FETCH: begin
                    if (InstMem_Ready) begin
                        state_nx_s = ST_FETCH;
                    end else begin
                        state_nx_s     = ST_DISCARD;
                        disc_addr_nx_s = pc_r[31:2];
                    end
                end
                // Already discarding: the old request is still the one in flight.
                ST_DISCARD: state_nx_s = InstMem_Ready ? ST_FETCH : ST_DISCARD;
                ST_HOLD:    state_nx_s = ST_FETCH;
                default:    state_nx_s = ST_FETCH;
            endcase
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (InstMem_Ready && ID_Stall) begin
                        hold_nx_s  = InstMem_In;
                        state_nx_s = ST_HOLD;
                    end else begin
                        state_nx_s = ST_FETCH;
                    end
                end
                ST_HOLD:    state_nx_s = ID_Stall ? ST_HOLD : ST_FETCH;
                ST_DISCARD: state_nx_s = InstMem_Ready ? ST_FETCH : ST_DISCARD;
                default:    state_nx_s = ST_FETCH;
            endcase

            if (deliver_s) begin
                pc_nx_s          = next_pc_s;
                bds_pending_nx_s = 1'b0;
                tgt_pending_nx_s = 1'b0;
            end else if (!ID_Stall && ID_IsBranch) begin
                // Branch leaves ID before its slot arrives: remember it.
                bds_pending_nx_s = 1'b1;
                if (ID_PCSrc) begin
                    tgt_pending_nx_s = 1'b1;
                    tgt_nx_s         = ID_BranchTarget;
                end else begin
                    tgt_pending_nx_s = tgt_pending_r;
                end
            end else begin
                bds_pending_nx_s = bds_pending_r;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r       <= ST_FETCH;
            pc_r          <= RESET_VECTOR;
            hold_r        <= 32'd0;
            tgt_r         <= 32'd0;
            disc_addr_r   <= 30'd0;
            bds_pending_r <= 1'b0;
            tgt_pending_r <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            pc_r          <= pc_nx_s;
            hold_r        <= hold_nx_s;
            tgt_r         <= tgt_nx_s;
            disc_addr_r   <= disc_addr_nx_s;
            bds_pending_r <= bds_pending_nx_s;
            tgt_pending_r <= tgt_pending_nx_s;
        end
    end

endmodule
